// File: rtl/controle_processador.sv
// rtl/controle_processador.sv - multicycle fetch/execute sequencer for the 16-bit processor
// Holds only the state register; every control output is decoded from state, IR and GNZ.
module controle_processador #(
  parameter int IR_W = 9
) (
  input  logic            Clock,
  input  logic            Clear,
  input  logic            Run,
  input  logic [IR_W-1:0] IR,
  input  logic            GNZ,
  output logic [7:0]      R_in,
  output logic [7:0]      R_out,
  output logic            G_out,
  output logic            DIN_out,
  output logic            A_in,
  output logic            G_in,
  output logic            AddSub,
  output logic            IR_in,
  output logic            ADDR_in,
  output logic            DOUT_in,
  output logic            W_D,
  output logic            Prox,
  output logic            Done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_F0   = 3'd1,
    S_F1   = 3'd2,
    S_F2   = 3'd3,
    S_E1   = 3'd4,
    S_E2   = 3'd5,
    S_E3   = 3'd6
  } state_t;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;

  state_t     r_state;
  logic [2:0] w_op;
  logic [7:0] w_rx_oh;
  logic [7:0] w_ry_oh;

  assign w_op    = IR[IR_W-1 -: 3];
  assign w_rx_oh = 8'b1 << IR[5:3];
  assign w_ry_oh = 8'b1 << IR[2:0];

  always_comb begin
    R_in    = 8'h00;
    R_out   = 8'h00;
    G_out   = 1'b0;
    DIN_out = 1'b0;
    A_in    = 1'b0;
    G_in    = 1'b0;
    AddSub  = 1'b0;
    IR_in   = 1'b0;
    ADDR_in = 1'b0;
    DOUT_in = 1'b0;
    W_D     = 1'b0;
    Prox    = 1'b0;
    Done    = 1'b0;
    case (r_state)
      S_F0: begin
        R_out   = 8'h80;
        ADDR_in = 1'b1;
        Prox    = 1'b1;
      end
      S_F2: begin
        DIN_out = 1'b1;
        IR_in   = 1'b1;
      end
      S_E1: begin
        case (w_op)
          OP_MV: begin
            R_out = w_ry_oh;
            R_in  = w_rx_oh;
            Done  = 1'b1;
          end
          OP_MVI: begin
            R_out   = 8'h80;
            ADDR_in = 1'b1;
            Prox    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            R_out = w_rx_oh;
            A_in  = 1'b1;
          end
          OP_LD, OP_ST: begin
            R_out   = w_ry_oh;
            ADDR_in = 1'b1;
          end
          OP_MVNZ: begin
            if (GNZ) begin
              R_out = w_ry_oh;
              R_in  = w_rx_oh;
            end
            Done = 1'b1;
          end
          default: Done = 1'b1;
        endcase
      end
      S_E2: begin
        case (w_op)
          OP_ADD, OP_SUB: begin
            R_out  = w_ry_oh;
            G_in   = 1'b1;
            AddSub = w_op[0];
          end
          OP_ST: begin
            R_out   = w_rx_oh;
            DOUT_in = 1'b1;
            W_D     = 1'b1;
            Done    = 1'b1;
          end
          default: ;
        endcase
      end
      S_E3: begin
        case (w_op)
          OP_MVI, OP_LD: begin
            DIN_out = 1'b1;
            R_in    = w_rx_oh;
            Done    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            G_out = 1'b1;
            R_in  = w_rx_oh;
            Done  = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // E3 always leaves, so an IR that changes mid-instruction cannot strand the sequencer.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      r_state <= S_IDLE;
    end else if (Done || r_state == S_E3) begin
      r_state <= Run ? S_F0 : S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  r_state <= Run ? S_F0 : S_IDLE;
        S_F0:    r_state <= S_F1;
        S_F1:    r_state <= S_F2;
        S_F2:    r_state <= S_E1;
        S_E1:    r_state <= S_E2;
        S_E2:    r_state <= S_E3;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_controle_processador.sv
// tb/tb_controle_processador.sv - table-driven scoreboard bench for controle_processador
// Expected per-cycle output vectors are queued as stimulus advances and compared on the falling edge.
module tb_controle_processador;

  logic       Clock = 1'b0;
  logic       Clear = 1'b1;
  logic       Run   = 1'b0;
  logic [8:0] IR    = 9'd0;
  logic       GNZ   = 1'b0;
  logic [7:0] R_in, R_out;
  logic       G_out, DIN_out, A_in, G_in, AddSub, IR_in, ADDR_in, DOUT_in, W_D, Prox, Done;

  always #5 Clock = ~Clock;

  controle_processador #(.IR_W(9)) dut (
    .Clock(Clock), .Clear(Clear), .Run(Run), .IR(IR), .GNZ(GNZ),
    .R_in(R_in), .R_out(R_out), .G_out(G_out), .DIN_out(DIN_out),
    .A_in(A_in), .G_in(G_in), .AddSub(AddSub), .IR_in(IR_in),
    .ADDR_in(ADDR_in), .DOUT_in(DOUT_in), .W_D(W_D), .Prox(Prox), .Done(Done)
  );

  // {R_in, R_out, G_out, DIN_out, A_in, G_in, AddSub, IR_in, ADDR_in, DOUT_in, W_D, Prox, Done}
  localparam logic [26:0] GOUT = 27'h400, DIN = 27'h200, AIN = 27'h100, GIN = 27'h080;
  localparam logic [26:0] ASUB = 27'h040, IRIN = 27'h020, ADDR = 27'h010, DOUT = 27'h008;
  localparam logic [26:0] WD = 27'h004, PROX = 27'h002, DONE = 27'h001, NONE = 27'h0;

  function automatic logic [26:0] rin(input logic [7:0] x);
    return {x, 19'd0};
  endfunction
  function automatic logic [26:0] rout(input logic [7:0] x);
    return {8'd0, x, 11'd0};
  endfunction

  logic [26:0] w_obs;
  assign w_obs = {R_in, R_out, G_out, DIN_out, A_in, G_in, AddSub, IR_in, ADDR_in, DOUT_in, W_D, Prox, Done};

  typedef struct {
    logic [8:0]  ir;
    logic        gnz;
    int          n;
    logic [26:0] e1, e2, e3;
  } vec_t;

  vec_t        tbl[$];
  logic [26:0] sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          inv_en = 1'b0;

  function automatic vec_t mk(input logic [8:0] ir, input logic gnz, input int n,
                              input logic [26:0] e1, input logic [26:0] e2, input logic [26:0] e3);
    vec_t v;
    v.ir = ir; v.gnz = gnz; v.n = n; v.e1 = e1; v.e2 = e2; v.e3 = e3;
    return v;
  endfunction

  always @(negedge Clock) begin
    logic [26:0] exp_v;
    cyc++;
    if (sb.size() > 0) begin
      exp_v = sb.pop_front();
      checks++;
      if (w_obs !== exp_v) begin
        failures++;
        $display("FAIL outputs cyc=%0d got=%h exp=%h", cyc, w_obs, exp_v);
      end
    end
    if (inv_en) begin
      checks++;
      if (($countones(R_out) + int'(G_out) + int'(DIN_out)) > 1 || $countones(R_in) > 1 || (Prox && R_in[7])) begin
        failures++;
        $display("FAIL invariant cyc=%0d got R_out=%h R_in=%h G_out=%b DIN_out=%b Prox=%b exp exclusive",
                 cyc, R_out, R_in, G_out, DIN_out, Prox);
      end
    end
  end

  task automatic step(input logic [26:0] e);
    sb.push_back(e);
    @(posedge Clock);
    #1;
  endtask

  localparam logic [26:0] F0 = 27'h0 | {8'd0, 8'h80, 11'd0} | 27'h010 | 27'h002;
  localparam logic [26:0] F2 = 27'h200 | 27'h020;

  initial begin
    tbl.push_back(mk(9'b000_011_110, 1'b0, 4, rout(8'h40) | rin(8'h08) | DONE, NONE, NONE));
    tbl.push_back(mk(9'b001_010_000, 1'b0, 6, rout(8'h80) | ADDR | PROX, NONE, DIN | rin(8'h04) | DONE));
    tbl.push_back(mk(9'b010_001_011, 1'b0, 6, rout(8'h02) | AIN, rout(8'h08) | GIN, GOUT | rin(8'h02) | DONE));
    tbl.push_back(mk(9'b011_001_011, 1'b0, 6, rout(8'h02) | AIN, rout(8'h08) | GIN | ASUB, GOUT | rin(8'h02) | DONE));
    tbl.push_back(mk(9'b110_000_101, 1'b1, 4, rout(8'h20) | rin(8'h01) | DONE, NONE, NONE));
    tbl.push_back(mk(9'b110_000_101, 1'b0, 4, DONE, NONE, NONE));
    tbl.push_back(mk(9'b111_010_011, 1'b1, 4, DONE, NONE, NONE));
    tbl.push_back(mk(9'b000_111_001, 1'b0, 4, rout(8'h02) | rin(8'h80) | DONE, NONE, NONE));
    tbl.push_back(mk(9'b100_101_010, 1'b0, 6, rout(8'h04) | ADDR, NONE, DIN | rin(8'h20) | DONE));
    tbl.push_back(mk(9'b101_100_110, 1'b0, 5, rout(8'h40) | ADDR, rout(8'h10) | DOUT | WD | DONE, NONE));

    @(posedge Clock);
    #1;
    inv_en = 1'b1;
    step(NONE);
    step(NONE);
    Clear = 1'b0;
    Run   = 1'b1;
    step(NONE);

    // Back-to-back with Run held; Run drops during E1 of the final st.
    for (int i = 0; i < tbl.size(); i++) begin
      IR  = tbl[i].ir;
      GNZ = tbl[i].gnz;
      step(F0);
      step(NONE);
      step(F2);
      if (i == tbl.size() - 1) Run = 1'b0;
      step(tbl[i].e1);
      if (tbl[i].n >= 5) step(tbl[i].e2);
      if (tbl[i].n >= 6) step(tbl[i].e3);
    end
    step(NONE);
    step(NONE);

    // Clear during E2 of ld: no Done, straight back to IDLE.
    Run = 1'b1;
    step(NONE);
    IR = 9'b100_011_010;
    step(F0);
    step(NONE);
    step(F2);
    step(rout(8'h04) | ADDR);
    Clear = 1'b1;
    step(NONE);
    step(NONE);
    Clear = 1'b0;
    Run   = 1'b0;
    step(NONE);
    step(NONE);

    Run = 1'b1;
    step(NONE);
    IR = 9'b000_001_100;
    step(F0);
    step(NONE);
    step(F2);
    Run = 1'b0;
    step(rout(8'h10) | rin(8'h02) | DONE);
    step(NONE);

    @(negedge Clock);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controle_processador.md
# controle_processador

Control unit for the 16-bit multicycle processor. It sequences fetch and execute for every instruction and drives the register-file load and output enables and the `Prox` increment of the `R7` program counter. It also drives the bus multiplexer selects, the ALU operand and result registers, the instruction register, and the memory address and write strobes. It sits between the instruction register output and the datapath enables; it holds no datapath values itself.

## Interface
- `IR_W`, default 9, instruction width: III XXX YYY (opcode, Rx, Ry).
- `Clock`, in, 1: system clock; all state updates on the rising edge.
- `Clear`, in, 1: synchronous, active-high reset.
- `Run`, in, 1: start/continue execution; sampled in IDLE and at each Done.
- `IR`, in, `IR_W`: current instruction register contents.
- `GNZ`, in, 1: high when datapath register G ≠ 0; used by mvnz.
- `R_in`, out, 8: one-hot load enable for R0..R7.
- `R_out`, out, 8: one-hot bus drive select for R0..R7.
- `G_out`, out, 1: G drives bus.
- `DIN_out`, out, 1: memory data in drives bus.
- `A_in`, out, 1: load ALU operand A from bus.
- `G_in`, out, 1: load G from ALU result.
- `AddSub`, out, 1: 0 means add (A + bus), 1 means subtract (A − bus).
- `IR_in`, out, 1: load IR from DIN.
- `ADDR_in`, out, 1: load memory address register from bus.
- `DOUT_in`, out, 1: load memory write-data register from bus.
- `W_D`, out, 1: memory write enable.
- `Prox`, out, 1: increment R7 (PC).
- `Done`, out, 1: single-cycle pulse on the final cycle of each instruction.

## Operation
- States: IDLE, F0, F1, F2, E1, E2, E3. The state register is the only storage; all outputs are combinational decodes of state, `IR` and `GNZ`.
- IDLE: all outputs 0. If `Run`=1, go to F0.
- F0: `R_out[7]`, `ADDR_in`, `Prox`. Go to F1.
- F1: no outputs (synchronous memory read latency). Go to F2.
- F2: `DIN_out`, `IR_in`. Go to E1.
- Opcode 000, mv Rx,Ry: E1 drives `R_out[Ry]`, `R_in[Rx]`, `Done`.
- Opcode 001, mvi Rx,#D:
  - E1: `R_out[7]`, `ADDR_in`, `Prox`.
  - E2: wait.
  - E3: `DIN_out`, `R_in[Rx]`, `Done`.
- Opcodes 010 add and 011 sub:
  - E1: `R_out[Rx]`, `A_in`.
  - E2: `R_out[Ry]`, `G_in`, `AddSub`=opcode[0].
  - E3: `G_out`, `R_in[Rx]`, `Done`.
- Opcode 100, ld Rx,[Ry]:
  - E1: `R_out[Ry]`, `ADDR_in`.
  - E2: wait.
  - E3: `DIN_out`, `R_in[Rx]`, `Done`.
- Opcode 101, st Rx,[Ry]:
  - E1: `R_out[Ry]`, `ADDR_in`.
  - E2: `R_out[Rx]`, `DOUT_in`, `W_D`, `Done`.
- Opcode 110, mvnz Rx,Ry: in E1, if `GNZ`=1, act as mv. If `GNZ`=0, assert `Done` only.
- Opcode 111, reserved: E1 asserts `Done` only (nop).
- After any Done cycle: if `Run`=1 go to F0, else go to IDLE.
- Bus exclusivity: at most one of `R_out[*]`, `G_out`, `DIN_out` is high in any cycle. `R_in` is at most one-hot.
- `Prox` and `R_in[7]` are never asserted in the same cycle.
- Rx=7 on mv, mvi, ld or add/sub writes the PC and therefore acts as a jump. The next F0 fetches from the new R7.

## Timing
- Reset: with `Clear` high at an edge, the next state is IDLE and all outputs are 0. `Clear` takes priority over every transition, including mid-instruction.
- An aborted instruction's partial effects remain in the datapath: PC already incremented, A or address register already loaded.
- Start: `Run` high at an edge in IDLE puts the block in F0 in the following cycle.
- Cycles per instruction, counting F0 through the Done cycle:
  - mv, mvnz, reserved: 4.
  - st: 5.
  - mvi, ld, add, sub: 6.
- `Done` is high for exactly one cycle per instruction.
- Back-to-back execution: with `Run` held high, F0 follows the Done cycle directly, with no idle gap.
- `Run` dropping mid-instruction has no effect until the Done cycle.
- `IR` must be stable from the cycle after F2 until Done. The block does not register it.
- `GNZ` is sampled combinationally in E1 of mvnz.

## Test plan
- Reset then fetch: assert `Clear` for 2 cycles, then `Clear`=0 and `Run`=1.
  - Required: all outputs 0 during reset.
  - Next cycle: `R_out`=8'h80, `ADDR_in`=1, `Prox`=1.
  - 2 cycles later: `IR_in`=1, `DIN_out`=1.
- mvi R2,#D (`IR`=9'b001_010_000):
  - E1: `Prox`=1, `ADDR_in`=1.
  - E3: `DIN_out`=1, `R_in`=8'h04, `Done`=1.
  - Exactly 6 cycles from F0 to Done.
- add R1,R3 then sub R1,R3:
  - E1: `R_out`=8'h02, `A_in`=1.
  - E2: `R_out`=8'h08, `G_in`=1, with `AddSub`=0 for add and 1 for sub.
  - E3: `G_out`=1, `R_in`=8'h02.
- mvnz R0,R5 (`IR`=9'b110_000_101):
  - With `GNZ`=1, E1 gives `R_out`=8'h20, `R_in`=8'h01, `Done`=1.
  - With `GNZ`=0, E1 gives `R_in`=0, `Done`=1.
- st R4,[R6]:
  - E1: `R_out`=8'h40, `ADDR_in`=1.
  - E2: `R_out`=8'h10, `DOUT_in`=1, `W_D`=1, `Done`=1.
  - Then with `Run`=0, the block returns to IDLE with all outputs 0.
- Abort and bus check:
  - Assert `Clear` during E2 of ld. Required: IDLE next cycle, `Done` never pulses for that ld.
  - Checker runs throughout all scenarios: at most one bus driver per cycle, `R_in` at most one-hot, `Prox` and `R_in[7]` never asserted together.
